// File: rtl/vector_uop_sequencer.sv
// Purpose: expands one decoded vector instruction into 2^lmul_log per-register micro-ops for a lane.
// Latency: an instruction accepted at edge t drives uop 0 after edge t; one uop per cycle, no bubble between groups.
// Backpressure: lane_stall freezes every output and the uop counter; instr_ready is low until the last uop fires.
module vector_uop_sequencer #(
    parameter int LANES_DATA_WIDTH = 64,
    parameter int MICROOP_BIT      = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    // instruction side
    input  logic                            instr_valid,
    output logic                            instr_ready,
    input  logic [MICROOP_BIT-1:0]          instr_alu_op,
    input  logic [4:0]                      instr_vs1,
    input  logic [4:0]                      instr_vs2,
    input  logic [4:0]                      instr_vd,
    input  logic                            instr_op1_is_vreg,
    input  logic [1:0]                      instr_lmul_log,
    input  logic [LANES_DATA_WIDTH-1:0]     instr_mask,
    input  logic                            instr_masked,
    input  logic                            instr_load,
    input  logic                            instr_store,
    input  logic                            instr_indexed,
    input  logic                            instr_wb_en,
    input  logic                            instr_mult,
    input  logic [LANES_DATA_WIDTH-1:0]     instr_imm,
    input  logic [LANES_DATA_WIDTH-1:0]     instr_scalar,
    input  logic [2:0]                      instr_sew,
    // lane side
    input  logic                            lane_stall,
    output logic                            uop_valid,
    output logic [MICROOP_BIT-1:0]          alu_op,
    output logic [4:0]                      operand_1,
    output logic [4:0]                      operand_2,
    output logic [4:0]                      destination,
    output logic [LANES_DATA_WIDTH/8-1:0]   mask_bits,
    output logic                            masked_operation,
    output logic                            load_operation,
    output logic                            store_operation,
    output logic                            indexed_memory_operation,
    output logic                            write_back_enable,
    output logic                            multiplication_flag,
    output logic [LANES_DATA_WIDTH-1:0]     operand_1_immediate,
    output logic [LANES_DATA_WIDTH-1:0]     operand_1_scalar,
    output logic [2:0]                      sew_in,
    output logic [2:0]                      uop_index,
    output logic                            uop_last
);

    localparam int MASK_W = LANES_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state, state_next;

    // group-invariant fields needed to build uops 1..N-1
    logic [4:0]                  vs1_q;
    logic [4:0]                  vs2_q;
    logic [4:0]                  vd_q;
    logic                        op1_vreg_q;
    logic [1:0]                  lmul_log_q;
    logic [LANES_DATA_WIDTH-1:0] mask_q;

    logic [2:0] idx;
    logic [2:0] idx_next;
    logic [2:0] last_idx;
    logic       fire;
    logic       accept;
    logic       advance;
    logic       retire;

    assign uop_valid   = (state == ISSUE);
    assign uop_index   = idx;
    assign idx_next    = idx + 3'd1;
    assign fire        = uop_valid && !lane_stall;
    assign uop_last    = uop_valid && (idx == last_idx);
    assign instr_ready = (state == IDLE) || (fire && uop_last);

    // index of the final uop for the latched group size
    always_comb begin
        last_idx = 3'd0;
        case (lmul_log_q)
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd1;
            2'd2:    last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and datapath controls: load a new group, step the index, or go idle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    if (uop_last) begin
                        if (instr_valid) begin
                            accept = 1'b1;
                        end else begin
                            retire     = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // latch the instruction and build registered uop outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx                      <= 3'd0;
            vs1_q                    <= 5'd0;
            vs2_q                    <= 5'd0;
            vd_q                     <= 5'd0;
            op1_vreg_q               <= 1'b0;
            lmul_log_q               <= 2'd0;
            mask_q                   <= '0;
            alu_op                   <= '0;
            operand_1                <= 5'd0;
            operand_2                <= 5'd0;
            destination              <= 5'd0;
            mask_bits                <= '0;
            masked_operation         <= 1'b0;
            load_operation           <= 1'b0;
            store_operation          <= 1'b0;
            indexed_memory_operation <= 1'b0;
            write_back_enable        <= 1'b0;
            multiplication_flag      <= 1'b0;
            operand_1_immediate      <= '0;
            operand_1_scalar         <= '0;
            sew_in                   <= 3'd0;
        end else if (accept) begin
            idx                      <= 3'd0;
            vs1_q                    <= instr_vs1;
            vs2_q                    <= instr_vs2;
            vd_q                     <= instr_vd;
            op1_vreg_q               <= instr_op1_is_vreg;
            lmul_log_q               <= instr_lmul_log;
            mask_q                   <= instr_mask;
            alu_op                   <= instr_alu_op;
            operand_1                <= instr_vs1;
            operand_2                <= instr_vs2;
            destination              <= instr_vd;
            mask_bits                <= instr_mask[MASK_W-1:0];
            masked_operation         <= instr_masked;
            load_operation           <= instr_load;
            store_operation          <= instr_store;
            indexed_memory_operation <= instr_indexed;
            write_back_enable        <= instr_wb_en;
            multiplication_flag      <= instr_mult;
            operand_1_immediate      <= instr_imm;
            operand_1_scalar         <= instr_scalar;
            sew_in                   <= instr_sew;
        end else if (advance) begin
            // register numbers wrap modulo 32; group legality is the decoder's job
            idx         <= idx_next;
            operand_1   <= op1_vreg_q ? (vs1_q + {2'b00, idx_next}) : vs1_q;
            operand_2   <= vs2_q + {2'b00, idx_next};
            destination <= vd_q + {2'b00, idx_next};
            mask_bits   <= mask_q[int'(idx_next) * MASK_W +: MASK_W];
        end else if (retire) begin
            // side-effecting flags must not look live while the lane sees no uop
            load_operation    <= 1'b0;
            store_operation   <= 1'b0;
            write_back_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_uop_sequencer.sv
module tb_vector_uop_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [8:0]  instr_alu_op;
    logic [4:0]  instr_vs1, instr_vs2, instr_vd;
    logic        instr_op1_is_vreg;
    logic [1:0]  instr_lmul_log;
    logic [63:0] instr_mask;
    logic        instr_masked, instr_load, instr_store, instr_indexed, instr_wb_en, instr_mult;
    logic [63:0] instr_imm, instr_scalar;
    logic [2:0]  instr_sew;
    logic        lane_stall;
    logic        uop_valid;
    logic [8:0]  alu_op;
    logic [4:0]  operand_1, operand_2, destination;
    logic [7:0]  mask_bits;
    logic        masked_operation, load_operation, store_operation;
    logic        indexed_memory_operation, write_back_enable, multiplication_flag;
    logic [63:0] operand_1_immediate, operand_1_scalar;
    logic [2:0]  sew_in;
    logic [2:0]  uop_index;
    logic        uop_last;

    vector_uop_sequencer #(.LANES_DATA_WIDTH(64), .MICROOP_BIT(9)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_alu_op(instr_alu_op), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vd(instr_vd),
        .instr_op1_is_vreg(instr_op1_is_vreg), .instr_lmul_log(instr_lmul_log), .instr_mask(instr_mask),
        .instr_masked(instr_masked), .instr_load(instr_load), .instr_store(instr_store),
        .instr_indexed(instr_indexed), .instr_wb_en(instr_wb_en), .instr_mult(instr_mult),
        .instr_imm(instr_imm), .instr_scalar(instr_scalar), .instr_sew(instr_sew),
        .lane_stall(lane_stall), .uop_valid(uop_valid), .alu_op(alu_op),
        .operand_1(operand_1), .operand_2(operand_2), .destination(destination), .mask_bits(mask_bits),
        .masked_operation(masked_operation), .load_operation(load_operation), .store_operation(store_operation),
        .indexed_memory_operation(indexed_memory_operation), .write_back_enable(write_back_enable),
        .multiplication_flag(multiplication_flag), .operand_1_immediate(operand_1_immediate),
        .operand_1_scalar(operand_1_scalar), .sew_in(sew_in), .uop_index(uop_index), .uop_last(uop_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  alu;
        logic [4:0]  vs1, vs2, vd;
        logic        vreg;
        logic [1:0]  lmul;
        logic [63:0] mask;
        logic        masked, ld, st, ix, wb, mult;
        logic [63:0] imm, scal;
        logic [2:0]  sew;
    } instr_t;

    typedef struct {
        logic [8:0]  alu;
        logic [4:0]  op1, op2, dst;
        logic [7:0]  mask;
        logic [2:0]  idx;
        logic        last;
        logic        masked, ld, st, ix, wb, mult;
        logic [63:0] imm, scal;
        logic [2:0]  sew;
    } uop_t;

    uop_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   valid_cycles = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                                  input logic vreg, input logic [1:0] lmul, input logic [63:0] mask);
        instr_t x;
        x.alu = 9'($urandom);   x.vs1 = vs1; x.vs2 = vs2; x.vd = vd;
        x.vreg = vreg;          x.lmul = lmul; x.mask = mask;
        x.masked = 1'($urandom); x.ld = 1'($urandom); x.st = 1'($urandom);
        x.ix = 1'($urandom);    x.wb = 1'($urandom); x.mult = 1'($urandom);
        x.imm = {$urandom, $urandom}; x.scal = {$urandom, $urandom};
        x.sew = 3'($urandom);
        return x;
    endfunction

    function automatic instr_t rand_instr();
        return mk(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 2'($urandom),
                  {$urandom, $urandom});
    endfunction

    task automatic apply(input instr_t x);
        instr_alu_op = x.alu; instr_vs1 = x.vs1; instr_vs2 = x.vs2; instr_vd = x.vd;
        instr_op1_is_vreg = x.vreg; instr_lmul_log = x.lmul; instr_mask = x.mask;
        instr_masked = x.masked; instr_load = x.ld; instr_store = x.st; instr_indexed = x.ix;
        instr_wb_en = x.wb; instr_mult = x.mult; instr_imm = x.imm; instr_scalar = x.scal;
        instr_sew = x.sew;
    endtask

    // Reference model: an accepted instruction becomes a list of 2^lmul uops built by plain arithmetic.
    task automatic expand_current();
        int n;
        uop_t u;
        n = 1 << instr_lmul_log;
        for (int i = 0; i < n; i++) begin
            u.alu  = instr_alu_op;
            u.op1  = instr_op1_is_vreg ? 5'((int'(instr_vs1) + i) % 32) : instr_vs1;
            u.op2  = 5'((int'(instr_vs2) + i) % 32);
            u.dst  = 5'((int'(instr_vd) + i) % 32);
            u.mask = 8'(instr_mask >> (8 * i));
            u.idx  = 3'(i);
            u.last = (i == n - 1);
            u.masked = instr_masked; u.ld = instr_load; u.st = instr_store;
            u.ix = instr_indexed; u.wb = instr_wb_en; u.mult = instr_mult;
            u.imm = instr_imm; u.scal = instr_scalar; u.sew = instr_sew;
            exp_q.push_back(u);
        end
    endtask

    // Scoreboard: compare the lane-facing outputs with the head of the expected uop list.
    always @(negedge clk) begin
        if (rst) begin
            if (uop_valid) valid_cycles++;
            if (exp_q.size() > 0) begin
                uop_t e;
                e = exp_q[0];
                check("uop_valid", {63'b0, uop_valid}, 64'd1);
                check("alu_op", {55'b0, alu_op}, {55'b0, e.alu});
                check("operand_1", {59'b0, operand_1}, {59'b0, e.op1});
                check("operand_2", {59'b0, operand_2}, {59'b0, e.op2});
                check("destination", {59'b0, destination}, {59'b0, e.dst});
                check("mask_bits", {56'b0, mask_bits}, {56'b0, e.mask});
                check("uop_index", {61'b0, uop_index}, {61'b0, e.idx});
                check("uop_last", {63'b0, uop_last}, {63'b0, e.last});
                check("flags", {58'b0, masked_operation, load_operation, store_operation,
                                indexed_memory_operation, write_back_enable, multiplication_flag},
                               {58'b0, e.masked, e.ld, e.st, e.ix, e.wb, e.mult});
                check("imm", operand_1_immediate, e.imm);
                check("scalar", operand_1_scalar, e.scal);
                check("sew_in", {61'b0, sew_in}, {61'b0, e.sew});
                check("instr_ready", {63'b0, instr_ready}, {63'b0, e.last && !lane_stall});
                if (!lane_stall) void'(exp_q.pop_front());
            end else begin
                check("idle_valid", {63'b0, uop_valid}, 64'd0);
                check("idle_wb_ld_st", {61'b0, write_back_enable, load_operation, store_operation}, 64'd0);
                check("idle_ready", {63'b0, instr_ready}, 64'd1);
            end
            if (instr_valid && instr_ready) expand_current();
        end
    end

    // Present x from posedge+1, hold valid until accepted; return at posedge+1 after the accepting edge.
    task automatic send(input instr_t x);
        logic got;
        got = 1'b0;
        apply(x);
        instr_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (instr_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_in_time", {63'b0, got}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!uop_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_in_time", {63'b0, done}, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        instr_t a, b;
        logic   took, pending, hit;
        int     sent;

        rst = 1'b0; instr_valid = 1'b0; lane_stall = 1'b0;
        apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 64'd0));
        #1;
        check("rst_valid", {63'b0, uop_valid}, 64'd0);
        check("rst_ready", {63'b0, instr_ready}, 64'd1);
        check("rst_last", {63'b0, uop_last}, 64'd0);
        check("rst_wb_ld_st", {61'b0, write_back_enable, load_operation, store_operation}, 64'd0);
        check("rst_regs", {operand_1, operand_2, destination, mask_bits, uop_index, alu_op, sew_in},
                          64'd0);
        check("rst_wide", operand_1_immediate | operand_1_scalar, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // group of one
        valid_cycles = 0;
        send(mk(5'd3, 5'd4, 5'd5, 1'b1, 2'd0, {$urandom, $urandom}));
        instr_valid = 1'b0;
        wait_idle();
        check("lmul1_cycles", 64'(valid_cycles), 64'd1);

        // LMUL=8 with immediate operand_1
        valid_cycles = 0;
        send(mk(5'd1, 5'd8, 5'd16, 1'b0, 2'd3, 64'h0102030405060708));
        instr_valid = 1'b0;
        wait_idle();
        check("lmul8_cycles", 64'(valid_cycles), 64'd8);

        // stall for three cycles while uop 1 is presented
        valid_cycles = 0;
        send(mk(5'd2, 5'd10, 5'd20, 1'b1, 2'd2, {$urandom, $urandom}));
        instr_valid = 1'b0;
        @(posedge clk); #1;
        lane_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 lane_stall = 1'b0;
        wait_idle();
        check("stall_cycles", 64'(valid_cycles), 64'd7);

        // register wrap-around
        valid_cycles = 0;
        send(mk(5'd7, 5'd31, 5'd30, 1'b1, 2'd2, {$urandom, $urandom}));
        instr_valid = 1'b0;
        wait_idle();
        check("wrap_cycles", 64'(valid_cycles), 64'd4);

        // back-to-back groups with valid held
        valid_cycles = 0;
        a = mk(5'd1, 5'd2, 5'd3, 1'b1, 2'd1, {$urandom, $urandom});
        b = mk(5'd9, 5'd10, 5'd11, 1'b0, 2'd1, {$urandom, $urandom});
        send(a);
        send(b);
        instr_valid = 1'b0;
        wait_idle();
        check("b2b_cycles", 64'(valid_cycles), 64'd4);

        // asynchronous reset at uop 2 of an 8-uop group
        send(mk(5'd4, 5'd5, 5'd6, 1'b1, 2'd3, {$urandom, $urandom}));
        instr_valid = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (uop_index == 3'd2 && uop_valid) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_idx2", {63'b0, hit}, 64'd1);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", {63'b0, uop_valid}, 64'd0);
        check("arst_ready", {63'b0, instr_ready}, 64'd1);
        check("arst_wb_ld_st", {61'b0, write_back_enable, load_operation, store_operation}, 64'd0);
        check("arst_dest", {59'b0, destination}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        valid_cycles = 0;
        repeat (10) @(posedge clk);
        #1;
        check("no_residual", 64'(valid_cycles), 64'd0);
        check("post_rst_ready", {63'b0, instr_ready}, 64'd1);

        // randomized traffic with random stalls and gaps
        took = 1'b0; pending = 1'b0; sent = 0;
        for (int c = 0; c < 4000 && (sent < 40 || pending); c++) begin
            if (took) pending = 1'b0;
            if (!pending && sent < 40 && $urandom_range(0, 2) != 0) begin
                apply(rand_instr());
                instr_valid = 1'b1;
                pending = 1'b1;
                sent++;
            end else if (!pending) begin
                instr_valid = 1'b0;
            end
            lane_stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            took = instr_valid && instr_ready;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        lane_stall = 1'b0;
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vector_uop_sequencer.md
# vector_uop_sequencer

Issue-side sequencer that sits directly upstream of each vector lane. It accepts one decoded vector instruction per handshake and expands its LMUL register group into consecutive per-register micro-ops. It drives the lane's instruction inputs (alu_op, operand_1/2, destination, mask_bits, flags, sew) with one micro-op per cycle, and holds the current micro-op while the lane stalls.

## Interface
- LANES_DATA_WIDTH, 64, lane datapath width; the per-uop mask slice is LANES_DATA_WIDTH/8 bits.
- MICROOP_BIT, 9, width of alu_op.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  decoded instruction available.
- instr_ready  out  1  sequencer accepts; a transfer happens when instr_valid && instr_ready.
- instr_alu_op  in  MICROOP_BIT  operation code.
- instr_vs1, instr_vs2, instr_vd  in  5 each  base registers of the groups.
- instr_op1_is_vreg  in  1  1: operand_1 is a vector register and increments per uop; 0: immediate/scalar, vs1 is held.
- instr_lmul_log  in  2  group size is 2^lmul_log uops (1, 2, 4 or 8).
- instr_mask  in  8*(LANES_DATA_WIDTH/8)  mask bits for the whole group; slice i feeds uop i.
- instr_masked, instr_load, instr_store, instr_indexed, instr_wb_en, instr_mult  in  1 each  forwarded flags.
- instr_imm, instr_scalar  in  LANES_DATA_WIDTH each  forwarded operands.
- instr_sew  in  3  forwarded element width.
- lane_stall  in  1  lane cannot consume this cycle.
- uop_valid  out  1  micro-op outputs are meaningful.
- alu_op  out  MICROOP_BIT.
- operand_1, operand_2, destination  out  5 each.
- mask_bits  out  LANES_DATA_WIDTH/8.
- masked_operation, load_operation, store_operation, indexed_memory_operation, write_back_enable, multiplication_flag  out  1 each.
- operand_1_immediate, operand_1_scalar  out  LANES_DATA_WIDTH each.
- sew_in  out  3  (named for the lane port it drives).
- uop_index  out  3  index i of the current uop.
- uop_last  out  1  current uop is i == 2^lmul_log − 1.

## Operation
- FSM has two states, IDLE and ISSUE.
- Accept: on a transfer, latch all instr_* fields and set i=0. The state becomes ISSUE.
- uop fires when uop_valid && !lane_stall.
- Uop i outputs:
  - operand_2 = vs2+i and destination = vd+i.
  - operand_1 = vs1+i if op1_is_vreg, else vs1.
  - mask_bits = instr_mask[i*W +: W], where W = LANES_DATA_WIDTH/8.
  - All other outputs are the latched fields, unchanged for the whole group.
- Register arithmetic is 5-bit modulo 32; vd=30 with a group of 4 gives 30, 31, 0, 1. Group legality is not checked.
- Non-last uop fires: i increments and the state stays ISSUE.
- Last uop fires:
  - With instr_valid high in the same cycle: the new instruction is accepted and its uop 0 is driven next cycle with no bubble.
  - Otherwise: the state returns to IDLE and uop_valid drops.
- instr_ready = (state==IDLE) || (uop_valid && uop_last && !lane_stall). It is combinational from state, stall and the counter, never from instr_valid.
- Stall: while lane_stall is high, every output and the counter hold their values. No new instruction is accepted during a stall on the last uop.
- uop_valid is 0 in IDLE. Payload outputs in IDLE keep their last values; write_back_enable, load_operation and store_operation are forced to 0 when uop_valid is 0.

## Timing
- Reset (rst low, asynchronous):
  - State goes to IDLE, i=0.
  - uop_valid, write_back_enable, load_operation, store_operation, uop_last and all other outputs are 0.
  - instr_ready is 1.
- Reset asserted mid-group aborts the group. Remaining uops are never issued; the first cycle after release is IDLE.
- Latency: accept at edge t puts uop 0 on the outputs after edge t.
- Throughput: 2^lmul_log uops in 2^lmul_log cycles without stall. Each stalled cycle adds exactly one cycle.
- All micro-op outputs are registered; nothing passes combinationally from instr_* to the lane ports.

## Test plan
- Group of one:
  - Stimulus: lmul_log=0, vs1=3, vs2=4, vd=5, op1_is_vreg=1.
  - Required: a single uop (3, 4, 5) with uop_last=1; instr_ready=1 in the same cycle; uop_valid=0 the following cycle.
- LMUL=8 group, immediate operand_1:
  - Stimulus: vs1=1, op1_is_vreg=0, vs2=8, vd=16, instr_mask=0x0102…08 pattern.
  - Required: operand_1 stays 1; operand_2 steps 8..15 and destination steps 16..23; mask_bits equals slice i each cycle; 8 consecutive uop_valid cycles.
- Stall mid-group:
  - Stimulus: lmul_log=2, lane_stall high for 3 cycles at i=1.
  - Required: outputs frozen at i=1 for those cycles; total issue spans 7 cycles; no index skipped or repeated.
- Wrap-around:
  - Stimulus: vd=30, vs2=31, lmul_log=2.
  - Required: destination sequence 30, 31, 0, 1; operand_2 sequence 31, 0, 1, 2.
- Back-to-back:
  - Stimulus: two lmul_log=1 instructions, instr_valid held high.
  - Required: 4 contiguous uop_valid cycles; second instruction accepted on the cycle the first one's last uop fires.
- Reset mid-group:
  - Stimulus: rst low at i=2 of an 8-uop group.
  - Required: uop_valid=0 immediately (asynchronous); after release, instr_ready=1 and no residual uops are issued.
